mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store at a time on a valid/ready bus and stalls M until it completes.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag MisalignW instead.
module mem_access_stage #(
  parameter logic [1:0] LOAD_SRC = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  output logic        StallM,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        MisalignW
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        is_store, is_load, mem_op, sz_byte, sz_half, misalign;
  logic [3:0]  be_m;
  logic [31:0] wdata_m;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        complete, load_done;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign is_store = MemWriteM;
  assign is_load  = ~MemWriteM & (ResultSrcM == LOAD_SRC);
  assign mem_op   = is_store | is_load;
  // Stores treat any funct3 other than 000/001 as a word; loads decode size from funct3[1:0].
  assign sz_byte  = is_store ? (funct3M == 3'b000) : (funct3M[1:0] == 2'b00);
  assign sz_half  = is_store ? (funct3M == 3'b001) : (funct3M[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (state_q == IDLE) & mem_op &
                    ((sz_half & ALUResultM[0]) |
                     (~sz_byte & ~sz_half & (ALUResultM[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    if (sz_byte) begin
      be_m    = 4'b0001 << ALUResultM[1:0];
      wdata_m = {4{WriteDataM[7:0]}};
    end else if (sz_half) begin
      be_m    = 4'b0011 << {ALUResultM[1], 1'b0};
      wdata_m = {2{WriteDataM[15:0]}};
    end else begin
      be_m    = '1;
      wdata_m = WriteDataM;
    end
  end

  always_comb begin
    state_d       = state_q;
    complete      = 1'b0;
    load_done     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_be    = '0;
    case (state_q)
      IDLE: begin
        if (!mem_op || misalign) begin
          complete = 1'b1;
        end else begin
          mem_req_valid = 1'b1;
          mem_req_we    = is_store;
          mem_req_addr  = {ALUResultM[31:2], 2'b00};
          mem_req_wdata = wdata_m;
          mem_req_be    = be_m;
          if (!mem_req_ready) state_d = REQ;
          else if (is_store)  complete = 1'b1;
          else                state_d = RSP;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        mem_req_be    = be_q;
        if (mem_req_ready) begin
          if (we_q) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = RSP;
          end
        end
      end
      RSP: begin
        if (mem_rsp_valid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence the bus immediately, before the state register is observed.
    if (rst) mem_req_valid = 1'b0;
  end

  assign StallM = ~rst & ~complete;

  always_comb begin
    ld_byte = mem_rsp_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        we_q    <= is_store;
        addr_q  <= {ALUResultM[31:2], 2'b00};
        wdata_q <= wdata_m;
        be_q    <= be_m;
        off_q   <= ALUResultM[1:0];
        f3_q    <= funct3M;
      end
    end
  end

  // Stalled cycles push a bubble; all W fields are cleared, not only RegWriteW/RdW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !complete) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      MisalignW  <= 1'b0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_done ? load_data : '0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~misalign;
      ResultSrcW <= ResultSrcM;
      MisalignW  <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized ops against a transaction-level model.
module tb_mem_access_stage;

  localparam logic [1:0] LOAD_SRC = 2'b01;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, PCPlus4M, WriteDataM;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic        StallM, mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic        MisalignW;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.LOAD_SRC(LOAD_SRC)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .RdM(RdM), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M),
    .StallM(StallM),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << (off & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return {24'd0, d[7:0]} * 32'h01010101;
    if (f3 == 3'd1) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (w >> (8 * (off & 2'b10))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [104:0] w_bus();
    return {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW};
  endfunction

  // kind: 0 = ALU pass-through, 1 = store, 2 = load. a = cycle index at which ready is given,
  // rw = extra idle cycles between acceptance and load response.
  task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] f3, input int a, input int rw, input logic [31:0] rdata);
    logic is_st, is_ld, memop, trap, sb, sh, rg;
    logic [1:0] off, rs;
    logic [4:0] rd;
    logic [31:0] pc, ld_val;
    int last;
    off   = addr[1:0];
    is_st = (kind == 1);
    is_ld = (kind == 2);
    memop = is_st || is_ld;
    sb    = is_st ? (f3 == 3'd0) : (f3 == 3'd0 || f3 == 3'd4);
    sh    = is_st ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
    trap  = TRAP && memop && ((sh && off[0]) || (!sb && !sh && off != 2'd0));
    if (!memop || trap) last = 0;
    else if (is_st)     last = a;
    else                last = a + 1 + rw;
    rd = 5'($urandom);
    pc = $urandom;
    rg = 1'($urandom);
    rs = 2'($urandom);
    if (is_ld) rs = LOAD_SRC;
    else if (is_st) rs = 2'b00;
    else if (rs == LOAD_SRC) rs = rs ^ 2'b10;
    ld_val = (is_ld && !trap) ? ref_load(f3, off, rdata) : 32'd0;

    @(negedge clk);
    ALUResultM = addr; WriteDataM = data; funct3M = f3; MemWriteM = is_st;
    ResultSrcM = rs; RdM = rd; PCPlus4M = pc; RegWriteM = rg;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) @(negedge clk);
      mem_req_ready = (c == a) ? 1'b1 : ((c < a) ? 1'b0 : 1'($urandom));
      mem_rsp_valid = (is_ld && !trap && c == last) ? 1'b1 : ((c <= a) ? 1'($urandom) : 1'b0);
      mem_rsp_rdata = (is_ld && c == last) ? rdata : $urandom;
      #1;
      check("stall", StallM, c < last);
      check("req_valid", mem_req_valid, memop && !trap && c <= a);
      if (memop && !trap && c <= a) begin
        if (is_st)
          check("req_store", {mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata},
                {1'b1, addr & ~32'd3, ref_be(f3, off), ref_wdata(f3, data)});
        else
          check("req_load", {mem_req_we, mem_req_addr}, {1'b0, addr & ~32'd3});
      end
      @(posedge clk);
      #1;
      if (c < last) check("bubble", {RegWriteW, RdW}, 6'd0);
      else check("writeback", w_bus(), {addr, ld_val, pc, rd, rg & ~trap, rs, trap});
    end
  endtask

  initial begin
    rst = 1'b1;
    ALUResultM = '0; PCPlus4M = '0; WriteDataM = '0; RdM = '0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = '0; funct3M = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    #1;
    check("reset_state", {StallM, mem_req_valid, w_bus()}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(1, 32'h104, 32'hDEADBEEF, 3'b010, 0, 0, 32'h0);
    run_op(1, 32'h103, 32'h000000A5, 3'b000, 0, 0, 32'h0);
    run_op(2, 32'h101, 32'h0, 3'b000, 0, 0, 32'h00008000);
    check("lb_value", ReadDataW, 32'hFFFFFF80);
    run_op(2, 32'h101, 32'h0, 3'b100, 0, 0, 32'h00008000);
    check("lbu_value", ReadDataW, 32'h00000080);
    run_op(2, 32'h200, 32'h0, 3'b010, 3, 1, 32'h13579BDF);
    run_op(2, 32'h201, 32'h0, 3'b001, 0, 0, 32'h1234ABCD);
    check("lh_misalign_flag", MisalignW, TRAP);
    run_op(1, 32'h302, 32'h0000BEEF, 3'b001, 2, 0, 32'h0);
    run_op(0, 32'h55AA55AA, 32'h0, 3'b000, 0, 0, 32'h0);

    // Reset while waiting for a load response; a late response must be ignored.
    @(negedge clk);
    ALUResultM = 32'h300; funct3M = 3'b010; MemWriteM = 1'b0; ResultSrcM = LOAD_SRC;
    RdM = 5'd3; RegWriteM = 1'b1; PCPlus4M = 32'h44;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    #1;
    check("rst_pre_valid", {StallM, mem_req_valid}, 2'b11);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {StallM, mem_req_valid, w_bus()}, '0);
    @(negedge clk);
    rst = 1'b0;
    ALUResultM = 32'hCAFE0000; MemWriteM = 1'b0; ResultSrcM = 2'b00; RdM = 5'd7;
    RegWriteM = 1'b1; PCPlus4M = 32'h48; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFFFFFF;
    #1;
    check("rst_late_rsp", {StallM, mem_req_valid}, 2'b00);
    @(posedge clk);
    #1;
    check("rst_after_wb", w_bus(), {32'hCAFE0000, 32'd0, 32'h48, 5'd7, 1'b1, 2'b00, 1'b0});
    run_op(1, 32'h400, 32'h11223344, 3'b010, 0, 0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      run_op(int'($urandom_range(0, 2)), $urandom, $urandom, 3'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
